// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control bundle between the multicycle FSM and the RV32I datapath
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    // Controller side
    modport slave (
        input  opcode, zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, instr_done, illegal, state
    );

    // Datapath side
    modport master (
        output opcode, zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, instr_done, illegal, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main FSM of the multicycle RV32I core
module multicycle_controller #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    multicycle_controller_if.slave      bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t     r_state;
    state_t     w_next;
    logic       r_illegal;
    logic       w_legal;
    logic       w_branch;
    logic       w_pcupdate;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_memwrite;
    logic       w_done;
    logic       w_adrsrc;
    logic [1:0] w_resultsrc;
    logic [1:0] w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;
    logic [1:0] w_immsrc;

    assign w_legal = (bus.opcode == OP_LW) || (bus.opcode == OP_SW) ||
                     (bus.opcode == OP_R)  || (bus.opcode == OP_I)  ||
                     (bus.opcode == OP_BEQ) || (bus.opcode == OP_JAL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE && !w_legal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_branch    = 1'b0;
        w_pcupdate  = 1'b0;
        w_irwrite   = 1'b0;
        w_regwrite  = 1'b0;
        w_memwrite  = 1'b0;
        w_done      = 1'b0;
        w_adrsrc    = 1'b0;
        w_resultsrc = 2'b00;
        w_alusrca   = 2'b00;
        w_alusrcb   = 2'b00;
        w_aluop     = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                w_irwrite   = bus.mem_ready;
                w_pcupdate  = bus.mem_ready;
                if (bus.mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut captures OldPC + imm so BEQ can use it as the target
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
                case (bus.opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECUTER;
                    OP_I:         w_next = S_EXECUTEI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    default: begin
                        if (ILLEGAL_HALT) begin
                            w_next = S_HALT;
                        end else begin
                            w_next = S_FETCH;
                            w_done = 1'b1;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_next    = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adrsrc = 1'b1;
                if (bus.mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
                w_done      = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
                if (bus.mem_ready) begin
                    w_done = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_EXECUTER: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
                w_next     = S_FETCH;
            end
            S_BEQ: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b01;
                w_branch  = 1'b1;
                w_done    = 1'b1;
                w_next    = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target now; rd gets OldPC + 4 in ALUWB
                w_alusrca  = 2'b01;
                w_alusrcb  = 2'b10;
                w_pcupdate = 1'b1;
                w_next     = S_ALUWB;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        case (bus.opcode)
            OP_SW:   w_immsrc = 2'b01;
            OP_BEQ:  w_immsrc = 2'b10;
            OP_JAL:  w_immsrc = 2'b11;
            default: w_immsrc = 2'b00;
        endcase
    end

    // Write enables are held low during reset so an abandoned instruction cannot commit
    assign bus.PCWrite    = reset_n & ((w_branch & bus.zero) | w_pcupdate);
    assign bus.IRWrite    = reset_n & w_irwrite;
    assign bus.RegWrite   = reset_n & w_regwrite;
    assign bus.MemWrite   = reset_n & w_memwrite;
    assign bus.instr_done = reset_n & w_done;
    assign bus.AdrSrc     = w_adrsrc;
    assign bus.ResultSrc  = w_resultsrc;
    assign bus.ALUSrcA    = w_alusrca;
    assign bus.ALUSrcB    = w_alusrcb;
    assign bus.ALUOp      = w_aluop;
    assign bus.ImmSrc     = w_immsrc;
    assign bus.illegal    = r_illegal;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed bench for multicycle_controller, both ILLEGAL_HALT settings
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    int         n_checks = 0;
    int         n_fail   = 0;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    always #5 clk = ~clk;

    multicycle_controller_if u_if_h();
    multicycle_controller_if u_if_n();

    assign u_if_h.opcode    = opcode;
    assign u_if_h.zero      = zero;
    assign u_if_h.mem_ready = mem_ready;
    assign u_if_n.opcode    = opcode;
    assign u_if_n.zero      = zero;
    assign u_if_n.mem_ready = mem_ready;

    multicycle_controller #(.ILLEGAL_HALT(1'b1)) u_dut_h (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if_h.slave)
    );

    multicycle_controller #(.ILLEGAL_HALT(1'b0)) u_dut_n (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if_n.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input int st, input bit pcw, input bit irw,
                       input bit rw, input bit mw, input bit done);
        #1;
        check({tag, ".state"},      32'(u_if_h.state),      32'(st));
        check({tag, ".PCWrite"},    32'(u_if_h.PCWrite),    32'(pcw));
        check({tag, ".IRWrite"},    32'(u_if_h.IRWrite),    32'(irw));
        check({tag, ".RegWrite"},   32'(u_if_h.RegWrite),   32'(rw));
        check({tag, ".MemWrite"},   32'(u_if_h.MemWrite),   32'(mw));
        check({tag, ".instr_done"}, 32'(u_if_h.instr_done), 32'(done));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        opcode    = OP_I;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #3;
        check("rst.state",    32'(u_if_h.state),    32'd0);
        check("rst.illegal",  32'(u_if_h.illegal),  32'd0);
        check("rst.PCWrite",  32'(u_if_h.PCWrite),  32'd0);
        check("rst.IRWrite",  32'(u_if_h.IRWrite),  32'd0);
        tick();
        reset_n = 1'b1;

        // lw, mem_ready high: 5 cycles
        opcode = OP_LW;
        cyc("lw_f", 0, 1, 1, 0, 0, 0);
        check("lw_f.AdrSrc",    32'(u_if_h.AdrSrc),    32'd0);
        check("lw_f.ALUSrcB",   32'(u_if_h.ALUSrcB),   32'd2);
        check("lw_f.ResultSrc", 32'(u_if_h.ResultSrc), 32'd2);
        tick();
        cyc("lw_d", 1, 0, 0, 0, 0, 0);
        check("lw_d.ALUSrcA", 32'(u_if_h.ALUSrcA), 32'd1);
        check("lw_d.ALUSrcB", 32'(u_if_h.ALUSrcB), 32'd1);
        tick();
        cyc("lw_ma", 2, 0, 0, 0, 0, 0);
        check("lw_ma.ALUSrcA", 32'(u_if_h.ALUSrcA), 32'd2);
        check("lw_ma.ImmSrc",  32'(u_if_h.ImmSrc),  32'd0);
        tick();
        cyc("lw_mr", 3, 0, 0, 0, 0, 0);
        check("lw_mr.AdrSrc", 32'(u_if_h.AdrSrc), 32'd1);
        tick();
        cyc("lw_wb", 4, 0, 0, 1, 0, 1);
        check("lw_wb.ResultSrc", 32'(u_if_h.ResultSrc), 32'd1);
        tick();

        // sw: one stall in FETCH, two stalls in MEMWRITE
        opcode    = OP_SW;
        mem_ready = 1'b0;
        cyc("sw_fs", 0, 0, 0, 0, 0, 0);
        tick();
        mem_ready = 1'b1;
        cyc("sw_f", 0, 1, 1, 0, 0, 0);
        tick();
        cyc("sw_d", 1, 0, 0, 0, 0, 0);
        check("sw_d.ImmSrc", 32'(u_if_h.ImmSrc), 32'd1);
        tick();
        cyc("sw_ma", 2, 0, 0, 0, 0, 0);
        tick();
        mem_ready = 1'b0;
        cyc("sw_mw0", 5, 0, 0, 0, 1, 0);
        check("sw_mw0.AdrSrc", 32'(u_if_h.AdrSrc), 32'd1);
        tick();
        cyc("sw_mw1", 5, 0, 0, 0, 1, 0);
        tick();
        mem_ready = 1'b1;
        cyc("sw_mw2", 5, 0, 0, 0, 1, 1);
        tick();

        // beq taken, then not taken
        opcode = OP_BEQ;
        for (int k = 0; k < 2; k++) begin
            zero = (k == 0);
            cyc("beq_f", 0, 1, 1, 0, 0, 0);
            tick();
            cyc("beq_d", 1, 0, 0, 0, 0, 0);
            tick();
            cyc(k == 0 ? "beq_t" : "beq_nt", 9, (k == 0), 0, 0, 0, 1);
            check("beq.ALUOp",  32'(u_if_h.ALUOp),  32'd1);
            check("beq.ImmSrc", 32'(u_if_h.ImmSrc), 32'd2);
            tick();
        end
        zero = 1'b0;

        // R-type then I-type
        for (int k = 0; k < 2; k++) begin
            opcode = (k == 0) ? OP_R : OP_I;
            cyc("alu_f", 0, 1, 1, 0, 0, 0);
            tick();
            cyc("alu_d", 1, 0, 0, 0, 0, 0);
            tick();
            cyc("alu_ex", (k == 0) ? 6 : 7, 0, 0, 0, 0, 0);
            check("alu_ex.ALUOp",   32'(u_if_h.ALUOp),   32'd2);
            check("alu_ex.ALUSrcA", 32'(u_if_h.ALUSrcA), 32'd2);
            check("alu_ex.ALUSrcB", 32'(u_if_h.ALUSrcB), 32'(k));
            tick();
            cyc("alu_wb", 8, 0, 0, 1, 0, 1);
            check("alu_wb.ResultSrc", 32'(u_if_h.ResultSrc), 32'd0);
            tick();
        end

        // jal
        opcode = OP_JAL;
        cyc("jal_f", 0, 1, 1, 0, 0, 0);
        tick();
        cyc("jal_d", 1, 0, 0, 0, 0, 0);
        check("jal_d.ImmSrc", 32'(u_if_h.ImmSrc), 32'd3);
        tick();
        cyc("jal_j", 10, 1, 0, 0, 0, 0);
        check("jal_j.ALUSrcA", 32'(u_if_h.ALUSrcA), 32'd1);
        check("jal_j.ALUSrcB", 32'(u_if_h.ALUSrcB), 32'd2);
        tick();
        cyc("jal_wb", 8, 0, 0, 1, 0, 1);
        tick();

        // reset asserted in EXECUTER
        opcode = OP_R;
        cyc("rx_f", 0, 1, 1, 0, 0, 0);
        tick();
        cyc("rx_d", 1, 0, 0, 0, 0, 0);
        tick();
        cyc("rx_ex", 6, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        check("rx_rst.state",    32'(u_if_h.state),    32'd0);
        check("rx_rst.RegWrite", 32'(u_if_h.RegWrite), 32'd0);
        check("rx_rst.PCWrite",  32'(u_if_h.PCWrite),  32'd0);
        check("rx_rst.IRWrite",  32'(u_if_h.IRWrite),  32'd0);
        tick();
        check("rx_hold.state",    32'(u_if_h.state),    32'd0);
        check("rx_hold.RegWrite", 32'(u_if_h.RegWrite), 32'd0);
        reset_n = 1'b1;
        cyc("rx_f2", 0, 1, 1, 0, 0, 0);
        tick();
        cyc("rx_d2", 1, 0, 0, 0, 0, 0);
        tick();
        cyc("rx_ex2", 6, 0, 0, 0, 0, 0);
        tick();
        cyc("rx_wb2", 8, 0, 0, 1, 0, 1);
        tick();

        // illegal opcode on both variants
        opcode = 7'b0000000;
        cyc("il_f", 0, 1, 1, 0, 0, 0);
        check("il_f.n_state", 32'(u_if_n.state), 32'd0);
        tick();
        cyc("il_d", 1, 0, 0, 0, 0, 0);
        check("il_d.n_done", 32'(u_if_n.instr_done), 32'd1);
        tick();
        check("il_h.state",   32'(u_if_h.state),   32'd15);
        check("il_h.illegal", 32'(u_if_h.illegal), 32'd1);
        check("il_n.state",   32'(u_if_n.state),   32'd0);
        check("il_n.illegal", 32'(u_if_n.illegal), 32'd1);

        // lw after the illegal opcode: halted variant stays dead, NOP variant executes
        opcode = OP_LW;
        for (int k = 0; k < 5; k++) begin
            cyc("halt", 15, 0, 0, 0, 0, 0);
            check("nlw.state",    32'(u_if_n.state),    32'(k));
            check("nlw.RegWrite", 32'(u_if_n.RegWrite), 32'(k == 4));
            tick();
        end
        check("nlw_end.state",   32'(u_if_n.state),   32'd0);
        check("nlw_end.illegal", 32'(u_if_n.illegal), 32'd1);
        check("halt_end.illegal", 32'(u_if_h.illegal), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
